// File: rtl/bus_arbiter_split_n.sv
// Serial-bus arbiter for NUM_INIT initiators: fixed-priority or round-robin, split-transaction park/resume, tenure timeout.
// Optional owner lock-hold across target_ack is enabled by defining ARB_LOCK_EN.
module bus_arbiter_split_n #(
    parameter int NUM_INIT       = 4,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int ID_W          = $clog2(NUM_INIT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_INIT-1:0] init_req,
    input  logic [NUM_INIT-1:0] init_lock,
    input  logic                target_ack,
    input  logic                split_ack,
    input  logic                split_req,
    output logic [NUM_INIT-1:0] init_grant,
    output logic                split_grant,
    output logic [ID_W-1:0]     owner_id,
    output logic                owner_valid,
    output logic                split_pending,
    output logic                timeout,
    output logic                split_err
);

    localparam int TEN_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int PAD_N = 1 << ID_W;

    typedef enum logic [1:0] {IDLE, OWN, RESUME} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     owner_reg, owner_next;
    logic [ID_W-1:0]     parked_reg, parked_next;
    logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic                split_pending_reg, split_pending_next;
    logic [TEN_W-1:0]    tenure_reg, tenure_next;
    logic                timeout_reg, timeout_next;
    logic                split_err_reg, split_err_next;
    logic                split_grant_reg, split_grant_next;
    logic [NUM_INIT-1:0] grant_reg;
    logic                valid_reg;
    logic                grant_en;

    logic [NUM_INIT-1:0] parked_mask, eligible, onehot_next, cand_elig;
    logic [PAD_N-1:0]    elig_pad, req_pad;
    logic [ID_W-1:0]     cand_id [NUM_INIT];
    logic [ID_W-1:0]     base_ptr, win_id, ptr_after;
    logic                win_found, owner_req, lock_hold, expire;
    logic [TEN_W-1:0]    tenure_inc;

    assign eligible  = init_req & ~parked_mask;
    assign elig_pad  = PAD_N'(eligible);
    assign req_pad   = PAD_N'(init_req);
    assign owner_req = req_pad[owner_reg];
    assign base_ptr  = (ARB_MODE != 0) ? rr_ptr_reg : '0;
    assign ptr_after = (win_id == ID_W'(NUM_INIT - 1)) ? '0 : win_id + 1'b1;
    assign expire    = (TIMEOUT_CYCLES != 0) && (tenure_reg == TEN_W'(TIMEOUT_CYCLES));
    assign tenure_inc = (&tenure_reg) ? tenure_reg : tenure_reg + 1'b1;

`ifdef ARB_LOCK_EN
    logic [PAD_N-1:0] lock_pad;
    assign lock_pad  = PAD_N'(init_lock);
    assign lock_hold = lock_pad[owner_reg] & owner_req;
`else
    logic unused_lock;
    assign unused_lock = ^init_lock;
    assign lock_hold   = 1'b0;
`endif

    // Candidate list rotated to start at the search base (0 in fixed mode).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INIT; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum            = {1'b0, base_ptr} + (ID_W+1)'(gi);
            assign cand_id[gi]    = (sum >= (ID_W+1)'(NUM_INIT)) ?
                                    ID_W'(sum - (ID_W+1)'(NUM_INIT)) : sum[ID_W-1:0];
            assign cand_elig[gi]  = elig_pad[cand_id[gi]];
            assign parked_mask[gi] = split_pending_reg && (parked_reg == ID_W'(gi));
            assign onehot_next[gi] = (owner_next == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_INIT - 1; i >= 0; i--) begin
            if (cand_elig[i]) begin
                win_found = 1'b1;
                win_id    = cand_id[i];
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        owner_next         = owner_reg;
        parked_next        = parked_reg;
        rr_ptr_next        = rr_ptr_reg;
        split_pending_next = split_pending_reg;
        tenure_next        = '0;
        timeout_next       = 1'b0;
        split_err_next     = 1'b0;
        split_grant_next   = 1'b0;
        grant_en           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (split_pending_reg && split_req) begin
                    state_next       = RESUME;
                    owner_next       = parked_reg;
                    tenure_next      = TEN_W'(1);
                    grant_en         = 1'b1;
                    split_grant_next = 1'b1;
                end else if (win_found) begin
                    state_next  = OWN;
                    owner_next  = win_id;
                    tenure_next = TEN_W'(1);
                    grant_en    = 1'b1;
                    if (ARB_MODE != 0) rr_ptr_next = ptr_after;
                end
            end
            OWN: begin
                grant_en    = 1'b1;
                tenure_next = tenure_inc;
                if (split_ack && !split_pending_reg) begin
                    split_pending_next = 1'b1;
                    parked_next        = owner_reg;
                    state_next         = IDLE;
                end else if (split_ack) begin
                    // A second split while one is parked cannot be tracked.
                    split_err_next = 1'b1;
                    state_next     = IDLE;
                end else if (target_ack) begin
                    if (lock_hold) tenure_next = TEN_W'(1);
                    else           state_next  = IDLE;
                end else if (!owner_req) begin
                    state_next = IDLE;
                end else if (expire) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
                if (state_next == IDLE) begin
                    grant_en    = 1'b0;
                    tenure_next = '0;
                end
            end
            RESUME: begin
                grant_en         = 1'b1;
                split_grant_next = 1'b1;
                tenure_next      = tenure_inc;
                if (target_ack || split_ack || expire) begin
                    split_err_next     = split_ack;
                    timeout_next       = expire && !target_ack && !split_ack;
                    split_pending_next = 1'b0;
                    parked_next        = '0;
                    state_next         = IDLE;
                    grant_en           = 1'b0;
                    split_grant_next   = 1'b0;
                    tenure_next        = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            owner_reg         <= '0;
            parked_reg        <= '0;
            rr_ptr_reg        <= '0;
            split_pending_reg <= 1'b0;
            tenure_reg        <= '0;
            timeout_reg       <= 1'b0;
            split_err_reg     <= 1'b0;
            split_grant_reg   <= 1'b0;
            grant_reg         <= '0;
            valid_reg         <= 1'b0;
        end else begin
            state_reg         <= state_next;
            owner_reg         <= owner_next;
            parked_reg        <= parked_next;
            rr_ptr_reg        <= rr_ptr_next;
            split_pending_reg <= split_pending_next;
            tenure_reg        <= tenure_next;
            timeout_reg       <= timeout_next;
            split_err_reg     <= split_err_next;
            split_grant_reg   <= split_grant_next;
            grant_reg         <= grant_en ? onehot_next : '0;
            valid_reg         <= grant_en;
        end
    end

    assign init_grant    = grant_reg;
    assign split_grant   = split_grant_reg;
    assign owner_id      = owner_reg;
    assign owner_valid   = valid_reg;
    assign split_pending = split_pending_reg;
    assign timeout       = timeout_reg;
    assign split_err     = split_err_reg;

endmodule
